// File: rtl/game_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_controller
//  Description : Frame-synchronous round sequencer for the two-ship arena.
//                Turns the start key and per-ship hit flags into countdown,
//                play, explosion and game-over phases. It keeps both scores
//                and pulses round_reset to re-centre the ships.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_round_controller #(
    parameter int unsigned COUNTDOWN_SECS = 3,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned EXPLODE_FRAMES = 120,
    parameter int unsigned WIN_SCORE      = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       hit_p1,
    input  logic       hit_p2,
    output logic       round_reset,
    output logic       play_en,
    output logic       explode_p1,
    output logic       explode_p2,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [3:0] countdown,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_EXPLODE   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [3:0] c_secs    = 4'(COUNTDOWN_SECS);
    localparam logic [7:0] c_frames  = 8'(FRAMES_PER_SEC);
    localparam logic [7:0] c_explode = 8'(EXPLODE_FRAMES);
    localparam logic [3:0] c_win     = 4'(WIN_SCORE);

    state_t     r_state,      w_state_nxt;
    logic       r_frame_q,    w_frame_q_nxt;
    logic       r_start_q,    w_start_q_nxt;
    logic [3:0] r_sec,        w_sec_nxt;
    logic [7:0] r_sub,        w_sub_nxt;
    logic [7:0] r_ex_cnt,     w_ex_cnt_nxt;
    logic [3:0] r_score_p1,   w_score_p1_nxt;
    logic [3:0] r_score_p2,   w_score_p2_nxt;
    logic [3:0] r_countdown,  w_countdown_nxt;
    logic [1:0] r_winner,     w_winner_nxt;
    logic       r_explode_p1, w_explode_p1_nxt;
    logic       r_explode_p2, w_explode_p2_nxt;
    logic       r_round_rst,  w_round_rst_nxt;
    logic       r_play_en,    w_play_en_nxt;
    logic       w_load_round;

    // One-Clk rising-edge strobes; the delayed copies reset high so a held
    // key or an already-high VS never counts as an edge after Reset.
    logic w_frame_tick;
    logic w_start_edge;
    assign w_frame_tick = frame_clk & ~r_frame_q;
    assign w_start_edge = start & ~r_start_q;

    // State and output register bank with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_frame_q    <= 1'b1;
            r_start_q    <= 1'b1;
            r_sec        <= '0;
            r_sub        <= '0;
            r_ex_cnt     <= '0;
            r_score_p1   <= '0;
            r_score_p2   <= '0;
            r_countdown  <= '0;
            r_winner     <= '0;
            r_explode_p1 <= 1'b0;
            r_explode_p2 <= 1'b0;
            r_round_rst  <= 1'b0;
            r_play_en    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_q    <= w_frame_q_nxt;
            r_start_q    <= w_start_q_nxt;
            r_sec        <= w_sec_nxt;
            r_sub        <= w_sub_nxt;
            r_ex_cnt     <= w_ex_cnt_nxt;
            r_score_p1   <= w_score_p1_nxt;
            r_score_p2   <= w_score_p2_nxt;
            r_countdown  <= w_countdown_nxt;
            r_winner     <= w_winner_nxt;
            r_explode_p1 <= w_explode_p1_nxt;
            r_explode_p2 <= w_explode_p2_nxt;
            r_round_rst  <= w_round_rst_nxt;
            r_play_en    <= w_play_en_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a phase changes it.
    always_comb begin
        w_state_nxt      = r_state;
        w_frame_q_nxt    = frame_clk;
        w_start_q_nxt    = start;
        w_sec_nxt        = r_sec;
        w_sub_nxt        = r_sub;
        w_ex_cnt_nxt     = r_ex_cnt;
        w_score_p1_nxt   = r_score_p1;
        w_score_p2_nxt   = r_score_p2;
        w_countdown_nxt  = r_countdown;
        w_winner_nxt     = r_winner;
        w_explode_p1_nxt = r_explode_p1;
        w_explode_p2_nxt = r_explode_p2;
        w_round_rst_nxt  = 1'b0;
        w_play_en_nxt    = r_play_en;
        w_load_round     = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_edge) begin
                    w_load_round   = 1'b1;
                    w_score_p1_nxt = '0;
                    w_score_p2_nxt = '0;
                    w_winner_nxt   = 2'b00;
                end
            end

            ST_COUNTDOWN: begin
                if (w_frame_tick) begin
                    if (r_sub == 8'd1) begin
                        if (r_sec == 4'd1) begin
                            w_state_nxt     = ST_PLAY;
                            w_countdown_nxt = '0;
                            w_play_en_nxt   = 1'b1;
                        end else begin
                            w_sec_nxt       = r_sec - 4'd1;
                            w_sub_nxt       = c_frames;
                            w_countdown_nxt = r_sec - 4'd1;
                        end
                    end else begin
                        w_sub_nxt = r_sub - 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (hit_p1 || hit_p2) begin
                    w_state_nxt      = ST_EXPLODE;
                    w_ex_cnt_nxt     = c_explode;
                    w_play_en_nxt    = 1'b0;
                    w_explode_p1_nxt = hit_p1;
                    w_explode_p2_nxt = hit_p2;
                    // A simultaneous hit is a draw and nobody scores.
                    if (hit_p1 && !hit_p2) begin
                        w_score_p2_nxt = r_score_p2 + 4'd1;
                    end else if (hit_p2 && !hit_p1) begin
                        w_score_p1_nxt = r_score_p1 + 4'd1;
                    end
                end
            end

            ST_EXPLODE: begin
                if (w_frame_tick) begin
                    if (r_ex_cnt == 8'd1) begin
                        w_explode_p1_nxt = 1'b0;
                        w_explode_p2_nxt = 1'b0;
                        if (r_score_p1 == c_win) begin
                            w_state_nxt  = ST_GAME_OVER;
                            w_winner_nxt = 2'b01;
                        end else if (r_score_p2 == c_win) begin
                            w_state_nxt  = ST_GAME_OVER;
                            w_winner_nxt = 2'b10;
                        end else begin
                            w_load_round = 1'b1;
                        end
                    end else begin
                        w_ex_cnt_nxt = r_ex_cnt - 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Entering a round: fresh countdown counters, ships re-centred.
        if (w_load_round) begin
            w_state_nxt     = ST_COUNTDOWN;
            w_sec_nxt       = c_secs;
            w_sub_nxt       = c_frames;
            w_countdown_nxt = c_secs;
            w_round_rst_nxt = 1'b1;
            w_play_en_nxt   = 1'b0;
        end
    end

    assign round_reset = r_round_rst;
    assign play_en     = r_play_en;
    assign explode_p1  = r_explode_p1;
    assign explode_p2  = r_explode_p2;
    assign score_p1    = r_score_p1;
    assign score_p2    = r_score_p2;
    assign countdown   = r_countdown;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Frame-synchronous game sequencer for the two-ship arena. It turns a start key and per-ship hit flags into round flow: countdown, play, explosion and game over. It also keeps both scores and issues the round restart pulse that re-centres the ships. It sits between the keycode decoder / collision logic and the ship controllers, color mapper and HEX displays.

Parameters:
COUNTDOWN_SECS, 3, seconds shown before each round (1..15)
FRAMES_PER_SEC, 60, frame ticks per countdown second (1..255)
EXPLODE_FRAMES, 120, frame ticks the explosion state lasts (1..255)
WIN_SCORE, 5, score that ends the game (1..15)

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high
frame_clk  in  1  VGA_VS; its rising edge defines a frame tick
start  in  1  start key level, active-high
hit_p1  in  1  ship 1 destroyed (level, sampled only in PLAY)
hit_p2  in  1  ship 2 destroyed (level, sampled only in PLAY)
round_reset  out  1  one-Clk pulse; ships return to their centre positions
play_en  out  1  ship motion / command enable
explode_p1  out  1  draw explosion for ship 1
explode_p2  out  1  draw explosion for ship 2
score_p1  out  4  ship 1 score
score_p2  out  4  ship 2 score
countdown  out  4  seconds remaining; 0 outside COUNTDOWN
winner  out  2  00 none, 01 p1, 10 p2
state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, EXPLODE=3, GAME_OVER=4

Behaviour:
- All outputs and state are registered.
- On Reset: state=IDLE; all outputs 0. Internal start_q and frame_q reset to 1, so a key already held or VS already high does not produce an edge.
- Reset mid-operation aborts immediately to IDLE. Scores clear.
- frame_tick = frame_clk & ~frame_q, where frame_q is frame_clk delayed one Clk. It is one Clk wide.
- start_edge = start & ~start_q, same scheme.
- IDLE:
  - start_edge -> COUNTDOWN; scores=0; winner=0.
  - Load sec=COUNTDOWN_SECS, sub=FRAMES_PER_SEC.
  - round_reset=1 for the single cycle in which state first reads COUNTDOWN.
- COUNTDOWN:
  - countdown=sec.
  - On frame_tick: sub decrements. When sub==1 on a tick, sub reloads and sec decrements.
  - When sec==1 and sub==1 on a tick -> PLAY, countdown=0.
  - Duration is exactly COUNTDOWN_SECS*FRAMES_PER_SEC ticks.
  - hit inputs are ignored.
- PLAY:
  - play_en=1.
  - hit_p1 only: score_p2+1, explode_p1=1.
  - hit_p2 only: score_p1+1, explode_p2=1.
  - Both in the same cycle: draw; no score change; both explode flags=1.
  - Any hit -> EXPLODE with ex_cnt=EXPLODE_FRAMES, play_en=0 in the same cycle.
- EXPLODE:
  - On frame_tick, ex_cnt decrements.
  - ex_cnt==1 on a tick: clear explode flags, then:
    - if score_p1==WIN_SCORE or score_p2==WIN_SCORE -> GAME_OVER, winner set (01 or 10).
    - otherwise -> COUNTDOWN with reload and round_reset pulse, as from IDLE.
  - Both scores can never reach WIN_SCORE together, because a draw does not score.
- GAME_OVER:
  - Scores and winner held; play_en=0.
  - start_edge behaves as from IDLE.
- Scores increment only in PLAY. WIN_SCORE<=15, so no overflow and no wrap handling is needed.
- A start_edge in COUNTDOWN, PLAY or EXPLODE is ignored.
- frame_tick and a state transition in the same cycle: the transition wins. Counters load fresh values, and that tick is not counted against the new state.

Test Plan:
Bench parameters: COUNTDOWN_SECS=3, FRAMES_PER_SEC=2, EXPLODE_FRAMES=4, WIN_SCORE=2.
- Reset, start held high during and after Reset -> state stays 0, no round_reset. Release then press start -> state=1, countdown=3, round_reset high exactly 1 cycle.
- Countdown from start -> countdown reads 3,3,2,2,1,1 across ticks. state=2 and play_en=1 on the 6th tick.
- In PLAY, pulse hit_p1 one cycle -> score_p2=1, explode_p1=1, state=3. After 4 ticks: state=1, round_reset pulse, explode_p1=0.
- In PLAY, assert hit_p1 and hit_p2 together -> scores unchanged, both explode flags=1, state=3.
- p1 scores twice (hit_p2 in two rounds) -> after the 2nd explosion, state=4, winner=01, score_p1=2. A start_edge -> state=1, scores 0, winner 0.
- Assert Reset mid-EXPLODE -> next cycle state=0, all outputs 0. Hits asserted in COUNTDOWN -> no score change.
